// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit, its decoder and the datapath ALU:
// opcodes, ALU operation codes, FSM state encoding and write-back selects.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 16;
  localparam int unsigned REG_ADDR_W  = 3;
  localparam int unsigned IMM_FIELD_W = 6;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_NOT   = 4'h6,
    OP_SHL   = 4'h7,
    OP_SHR   = 4'h8,
    OP_LDI   = 4'h9,
    OP_LOAD  = 4'hA,
    OP_STORE = 4'hB,
    OP_JMP   = 4'hC,
    OP_JZ    = 4'hD,
    OP_HALT  = 4'hE,
    OP_MOV   = 4'hF
  } opcode_e;

  // ALU codes deliberately coincide with the ALU opcodes; MOV is a pass-through.
  typedef enum logic [3:0] {
    ALU_NONE = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_AND  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_NOT  = 4'h6,
    ALU_SHL  = 4'h7,
    ALU_SHR  = 4'h8,
    ALU_MOV  = 4'hF
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_IMM = 2'd1,
    WB_MEM = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LDI,
    CLS_LOAD,
    CLS_STORE,
    CLS_JMP,
    CLS_JZ,
    CLS_HALT
  } instr_class_e;

  typedef struct packed {
    alu_op_e                 alu_op;
    instr_class_e            iclass;
    logic [REG_ADDR_W-1:0]   rd_addr;
    logic [REG_ADDR_W-1:0]   rs_addr;
    logic [INSTR_WIDTH-1:0]  imm;
  } decode_t;

  function automatic wb_sel_e wb_sel_for(input instr_class_e iclass);
    case (iclass)
      CLS_LDI:  return WB_IMM;
      CLS_LOAD: return WB_MEM;
      default:  return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decode: ir -> ALU op, instruction class
// and register/immediate field extracts.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0] i_ir,
  output decode_t                o_dec
);

  logic [3:0] w_opcode;

  assign w_opcode = i_ir[15:12];

  // NOTE: every field gets a default before the case so no path can infer a latch.
  always_comb begin
    o_dec         = '0;
    o_dec.rd_addr = i_ir[11:9];
    o_dec.rs_addr = i_ir[8:6];
    o_dec.imm     = {{(INSTR_WIDTH-IMM_FIELD_W){1'b0}}, i_ir[IMM_FIELD_W-1:0]};
    o_dec.iclass  = CLS_NOP;
    o_dec.alu_op  = ALU_NONE;

    case (w_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        o_dec.iclass = CLS_ALU;
        o_dec.alu_op = alu_op_e'(w_opcode);
      end
      OP_MOV: begin
        o_dec.iclass = CLS_ALU;
        o_dec.alu_op = ALU_MOV;
      end
      OP_LDI:   o_dec.iclass = CLS_LDI;
      OP_LOAD:  o_dec.iclass = CLS_LOAD;
      OP_STORE: o_dec.iclass = CLS_STORE;
      OP_JMP:   o_dec.iclass = CLS_JMP;
      OP_JZ:    o_dec.iclass = CLS_JZ;
      OP_HALT:  o_dec.iclass = CLS_HALT;
      default:  o_dec.iclass = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT FSM
// owning pc, ir and the zero flag; decode is delegated to instr_decoder.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   mem_ready,
  input  logic                   alu_zero,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [3:0]             alu_op,
  output logic [REG_ADDR_W-1:0]  rd_addr,
  output logic [REG_ADDR_W-1:0]  rs_addr,
  output logic [INSTR_WIDTH-1:0] imm,
  output logic                   reg_write,
  output logic [1:0]             wb_sel,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   zero_flag,
  output logic                   halted
);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    w_pc_next;
  logic [PC_WIDTH-1:0]    w_pc_inc;
  logic [PC_WIDTH-1:0]    w_jump_target;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic                   r_zero;
  logic                   w_ir_load;
  logic                   w_zero_load;
  logic                   w_reg_write;
  logic                   w_mem_read;
  logic                   w_mem_write;
  logic                   w_halted;
  wb_sel_e                w_wb_sel;
  decode_t                w_dec;

  instr_decoder u_decoder (
    .i_ir  (r_ir),
    .o_dec (w_dec)
  );

  // Natural overflow of the adder gives the modulo-2^PC_WIDTH wrap.
  assign w_pc_inc      = r_pc + PC_WIDTH'(1);
  assign w_jump_target = r_ir[PC_WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_ir_load)   r_ir   <= instr_in;
      if (w_zero_load) r_zero <= alu_zero;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_load    = 1'b0;
    w_zero_load  = 1'b0;
    w_reg_write  = 1'b0;
    w_wb_sel     = WB_ALU;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_halted     = 1'b0;

    case (r_state)
      ST_FETCH: begin
        w_ir_load    = 1'b1;
        w_state_next = ST_DECODE;
      end

      ST_DECODE: w_state_next = ST_EXECUTE;

      ST_EXECUTE: begin
        case (w_dec.iclass)
          CLS_ALU, CLS_LDI:    w_state_next = ST_WRITEBACK;
          CLS_LOAD, CLS_STORE: w_state_next = ST_MEM;
          CLS_JMP: begin
            w_pc_next    = w_jump_target;
            w_state_next = ST_FETCH;
          end
          CLS_JZ: begin
            w_pc_next    = r_zero ? w_jump_target : w_pc_inc;
            w_state_next = ST_FETCH;
          end
          CLS_HALT: w_state_next = ST_HALT;
          default: begin
            w_pc_next    = w_pc_inc;
            w_state_next = ST_FETCH;
          end
        endcase
      end

      // Request held until the memory acknowledges; mem_ready is only looked at here.
      ST_MEM: begin
        w_mem_read  = (w_dec.iclass == CLS_LOAD);
        w_mem_write = (w_dec.iclass == CLS_STORE);
        if (mem_ready) begin
          if (w_dec.iclass == CLS_LOAD) begin
            w_state_next = ST_WRITEBACK;
          end else begin
            w_pc_next    = w_pc_inc;
            w_state_next = ST_FETCH;
          end
        end
      end

      ST_WRITEBACK: begin
        w_reg_write  = 1'b1;
        w_wb_sel     = wb_sel_for(w_dec.iclass);
        w_zero_load  = (w_dec.iclass == CLS_ALU);
        w_pc_next    = w_pc_inc;
        w_state_next = ST_FETCH;
      end

      ST_HALT: w_halted = 1'b1;

      default: w_state_next = ST_FETCH;
    endcase
  end

  assign pc        = r_pc;
  assign ir        = r_ir;
  assign alu_op    = w_dec.alu_op;
  assign rd_addr   = w_dec.rd_addr;
  assign rs_addr   = w_dec.rs_addr;
  assign imm       = w_dec.imm;
  assign reg_write = w_reg_write;
  assign wb_sel    = w_wb_sel;
  assign mem_read  = w_mem_read;
  assign mem_write = w_mem_write;
  assign zero_flag = r_zero;
  assign halted    = w_halted;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: PC_WIDTH, 8, program-counter width in bits.
REQ-002 Ports (name, direction, width, meaning):
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  synchronous active-high reset.
- instr_in  input  16  instruction-memory read data at address pc.
- mem_ready  input  1  data-memory completion strobe.
- alu_zero  input  1  ALU zero output for the current alu_op/operands.
- pc  output  PC_WIDTH  program counter.
- ir  output  16  latched instruction register.
- alu_op  output  4  ALU operation select.
- rd_addr  output  3  destination/first-operand register, ir[11:9].
- rs_addr  output  3  source/second-operand register, ir[8:6].
- imm  output  16  ir[5:0] zero-extended.
- reg_write  output  1  register-file write enable.
- wb_sel  output  2  write-back source: 0 ALU, 1 imm, 2 memory.
- mem_read  output  1  data-memory read request.
- mem_write  output  1  data-memory write request.
- zero_flag  output  1  registered zero flag.
- halted  output  1  high while in HALT.

Function
REQ-003 Opcode field ir[15:12] SHALL be interpreted as follows.
- 0x0: NOP.
- 0x1-0x8: ADD, SUB, AND, OR, XOR, NOT, SHL, SHR; alu_op equals the opcode.
- 0x9: LDI.
- 0xA: LOAD.
- 0xB: STORE.
- 0xC: JMP.
- 0xD: JZ.
- 0xE: HALT.
- 0xF: MOV; alu_op = 4'hF.
REQ-004 FSM states SHALL be FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT; exactly one transition per clock.
REQ-005 FETCH SHALL load ir from instr_in and go to DECODE; pc is unchanged.
REQ-006 DECODE SHALL drive alu_op, rd_addr, rs_addr, imm from ir and go to EXECUTE.
REQ-007 alu_op SHALL be 4'h0 for every non-ALU opcode.
REQ-008 alu_op SHALL remain stable from DECODE through WRITEBACK.
REQ-009 EXECUTE transitions SHALL be:
- ALU ops, MOV, LDI: to WRITEBACK.
- LOAD, STORE: to MEM.
- JMP, JZ, NOP: to FETCH.
- HALT: to the HALT state.
REQ-010 JMP SHALL load pc with ir[PC_WIDTH-1:0] on leaving EXECUTE.
REQ-011 JZ SHALL load the same target when zero_flag=1; otherwise pc increments.
REQ-012 NOP SHALL increment pc on leaving EXECUTE.
REQ-013 MEM SHALL assert mem_read (LOAD) or mem_write (STORE) continuously until mem_ready is sampled high; both SHALL never be high together.
REQ-014 On the mem_ready cycle, LOAD SHALL go to WRITEBACK; STORE SHALL go to FETCH with pc+1; mem_ready outside MEM SHALL be ignored.
REQ-015 WRITEBACK SHALL assert reg_write for exactly one cycle.
REQ-016 wb_sel SHALL be 0 for ALU/MOV, 1 for LDI, 2 for LOAD.
REQ-017 WRITEBACK SHALL increment pc and go to FETCH.
REQ-018 zero_flag SHALL capture alu_zero in WRITEBACK of ALU/MOV ops only and hold otherwise.
REQ-019 pc arithmetic SHALL be modulo 2^PC_WIDTH, so the maximum value wraps to 0.
REQ-020 HALT SHALL assert halted, hold all enables low and pc frozen, and exit only via rst.
REQ-021 Instruction latency SHALL be:
- ALU/MOV/LDI: 4 cycles.
- NOP/JMP/JZ: 3 cycles.
- LOAD: 4 cycles plus MEM wait.
- STORE: 3 cycles plus MEM wait.
- MEM wait is at least 1 cycle.

Reset
REQ-022 rst sampled high SHALL set state to FETCH and clear pc, ir, alu_op, reg_write, wb_sel, mem_read, mem_write, zero_flag and halted to 0 on the next edge.
REQ-023 rst SHALL take priority over every transition, including mid-MEM: a pending request is dropped and no write-back occurs.

Structure
REQ-024 Shared package cpu_pkg SHALL hold opcode constants, ALU op codes (shared with the ALU), FSM state encoding and wb_sel encodings.
REQ-025 Combinational decode SHALL be one sub-module, instr_decoder (ir -> alu_op, class flags, field extracts); the FSM and registers stay in control_unit.

Verification
REQ-026 Reset, then ADD R1,R2 (0x1280) -> reg_write high exactly in cycle 4, wb_sel=0, alu_op=1, pc=1 after.
REQ-027 SUB with alu_zero=1, then JZ 0x40 (0xD040) -> zero_flag=1, pc=0x40 three cycles after the JZ fetch; repeat with alu_zero=0 -> pc increments.
REQ-028 LOAD with mem_ready delayed 3 cycles -> mem_read high 3 cycles, then reg_write with wb_sel=2.
REQ-029 STORE with mem_ready after 2 cycles -> mem_write high 2 cycles, no reg_write, pc+1.
REQ-030 NOP at pc=0xFF -> pc wraps to 0x00.
REQ-031 HALT (0xE000) -> halted=1 and pc frozen for 20 cycles; rst asserted mid-LOAD MEM -> mem_read low and state FETCH, pc=0 next cycle.
